muldiv_wb_unit: RTL and testbench

Iterative signed 32-bit multiply/divide unit that sits directly upstream of the register file write port. It accepts one operation at a time with a destination register index and computes over multiple cycles. It then presents the result as a write request (register index, data, exception) that the writeback arbiter forwards to the regfile's ctrl_writeEnable, ctrl_writeReg and data_writeReg inputs.

---
 rtl/muldiv_wb_unit.sv | 152 +++++++++++++++
 tb/tb_muldiv_wb_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_wb_unit.sv
// Iterative signed 32-bit multiply (radix-2 Booth) / divide (restoring) unit that
// presents its result as a register-file write request with a valid/ready handshake.
module muldiv_wb_unit #(
    parameter int WIDTH    = 32,
    parameter int REG_ADDR = 5,
    parameter int ITERS    = 32
) (
    input  logic                clock,
    input  logic                ctrl_reset,
    input  logic                ctrl_MULT,
    input  logic                ctrl_DIV,
    input  logic [WIDTH-1:0]    data_operandA,
    input  logic [WIDTH-1:0]    data_operandB,
    input  logic [REG_ADDR-1:0] ctrl_destReg,
    output logic                busy,
    output logic                wb_valid,
    input  logic                wb_ready,
    output logic [REG_ADDR-1:0] wb_reg,
    output logic [WIDTH-1:0]    wb_data,
    output logic                wb_exception
);
    localparam int CW = $clog2(ITERS);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t              state, next_state;
    logic [CW-1:0]       cnt;
    logic [WIDTH:0]      acc;      // Booth high half / division remainder
    logic [WIDTH-1:0]    lo;       // Booth multiplier-product / division quotient
    logic                qm1;
    logic [WIDTH-1:0]    mcand;    // multiplicand, or divisor magnitude
    logic                neg;
    logic [REG_ADDR-1:0] dest;

    logic                last, div_zero;
    state_t              finish_state;
    logic [WIDTH-1:0]    abs_a, abs_b;
    logic [WIDTH:0]      m_ext, booth_sum, booth_acc;
    logic [WIDTH-1:0]    booth_lo;
    logic                mul_ovf;
    logic [WIDTH:0]      div_shift, div_trial, div_acc;
    logic [WIDTH-1:0]    div_lo, quotient;
    logic                div_ok, div_ovf;

    assign last         = (cnt == CW'(ITERS - 1));
    assign div_zero     = (mcand == '0);
    assign finish_state = (dest == '0) ? IDLE : DONE;
    assign abs_a        = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign abs_b        = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        m_ext     = {mcand[WIDTH-1], mcand};
        booth_sum = acc;
        case ({lo[0], qm1})
            2'b01:   booth_sum = acc + m_ext;
            2'b10:   booth_sum = acc - m_ext;
            default: booth_sum = acc;
        endcase
        booth_acc = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        booth_lo  = {booth_sum[0], lo[WIDTH-1:1]};
        // The 64-bit product overflows 32 bits unless the high half is pure sign extension.
        mul_ovf   = (booth_acc[WIDTH-1:0] != {WIDTH{booth_lo[WIDTH-1]}});

        div_shift = {acc[WIDTH-1:0], lo[WIDTH-1]};
        div_trial = div_shift - {1'b0, mcand};
        div_ok    = ~div_trial[WIDTH];
        div_acc   = div_ok ? div_trial : div_shift;
        div_lo    = {lo[WIDTH-2:0], div_ok};
        quotient  = neg ? -div_lo : div_lo;
        // Only a positive quotient of 2^31 (MIN / -1) cannot be represented.
        div_ovf   = ~neg & div_lo[WIDTH-1];
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) state <= IDLE;
        else            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (ctrl_MULT ^ ctrl_DIV) next_state = ctrl_MULT ? MUL : DIV;
            MUL:  if (last) next_state = finish_state;
            DIV:  if (div_zero || last) next_state = finish_state;
            DONE: if (wb_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != IDLE);
        wb_valid = (state == DONE);
    end

    // NOTE: datapath registers are reset too, so outputs are clean zeros after an abort.
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            cnt          <= '0;
            acc          <= '0;
            lo           <= '0;
            qm1          <= 1'b0;
            mcand        <= '0;
            neg          <= 1'b0;
            dest         <= '0;
            wb_reg       <= '0;
            wb_data      <= '0;
            wb_exception <= 1'b0;
        end else begin
            case (state)
                IDLE: if (ctrl_MULT ^ ctrl_DIV) begin
                    cnt   <= '0;
                    acc   <= '0;
                    qm1   <= 1'b0;
                    neg   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                    dest  <= ctrl_destReg;
                    lo    <= ctrl_MULT ? data_operandA : abs_a;
                    mcand <= ctrl_MULT ? data_operandB : abs_b;
                end
                MUL: begin
                    acc <= booth_acc;
                    lo  <= booth_lo;
                    qm1 <= lo[0];
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        wb_reg       <= dest;
                        wb_data      <= booth_lo;
                        wb_exception <= mul_ovf;
                    end
                end
                DIV: begin
                    if (div_zero) begin
                        wb_reg       <= dest;
                        wb_data      <= '0;
                        wb_exception <= 1'b1;
                    end else begin
                        acc <= div_acc;
                        lo  <= div_lo;
                        cnt <= cnt + 1'b1;
                        if (last) begin
                            wb_reg       <= dest;
                            wb_data      <= quotient;
                            wb_exception <= div_ovf;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_wb_unit.sv
// Directed bench for muldiv_wb_unit: latency, results, overflow flags, backpressure,
// asynchronous abort and ignored start pulses, with hand-computed expectations.
`timescale 1ns/1ps
module tb_muldiv_wb_unit;
    logic        clock = 1'b0;
    logic        ctrl_reset;
    logic        ctrl_MULT, ctrl_DIV;
    logic [31:0] data_operandA, data_operandB;
    logic [4:0]  ctrl_destReg;
    logic        busy, wb_valid, wb_ready, wb_exception;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;

    int errors = 0;
    int checks = 0;

    muldiv_wb_unit dut (
        .clock         (clock),
        .ctrl_reset    (ctrl_reset),
        .ctrl_MULT     (ctrl_MULT),
        .ctrl_DIV      (ctrl_DIV),
        .data_operandA (data_operandA),
        .data_operandB (data_operandB),
        .ctrl_destReg  (ctrl_destReg),
        .busy          (busy),
        .wb_valid      (wb_valid),
        .wb_ready      (wb_ready),
        .wb_reg        (wb_reg),
        .wb_data       (wb_data),
        .wb_exception  (wb_exception)
    );

    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Launch one operation with wb_ready=1, verify exact latency, result and return to IDLE.
    task automatic run_op(input string name, input logic mult, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] dest, input int lat,
                          input logic [31:0] exp_data, input logic exp_exc);
        logic saw;
        @(negedge clock);
        ctrl_MULT = mult; ctrl_DIV = ~mult;
        data_operandA = a; data_operandB = b; ctrl_destReg = dest; wb_ready = 1'b1;
        @(negedge clock);
        ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
        data_operandA = $urandom; data_operandB = $urandom; ctrl_destReg = 5'($urandom);
        check({name, "_busy_e0"}, 32'(busy), 32'd1);
        saw = wb_valid;
        for (int i = 1; i < lat; i++) begin
            @(negedge clock);
            saw |= wb_valid;
        end
        check({name, "_valid_early"}, 32'(saw), 32'd0);
        @(negedge clock);
        check({name, "_valid"}, 32'(wb_valid), 32'd1);
        check({name, "_reg"}, 32'(wb_reg), 32'(dest));
        check({name, "_data"}, wb_data, exp_data);
        check({name, "_exc"}, 32'(wb_exception), 32'(exp_exc));
        @(negedge clock);
        check({name, "_busy_after"}, 32'(busy), 32'd0);
        check({name, "_valid_after"}, 32'(wb_valid), 32'd0);
        check({name, "_data_held"}, wb_data, exp_data);
    endtask

    initial begin
        logic saw;
        ctrl_reset = 1'b1; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
        data_operandA = '0; data_operandB = '0; ctrl_destReg = '0; wb_ready = 1'b1;
        repeat (2) @(negedge clock);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(wb_valid), 32'd0);
        check("rst_data", wb_data, 32'd0);
        check("rst_reg", 32'(wb_reg), 32'd0);
        ctrl_reset = 1'b0;

        run_op("mul_7x-3",     1'b1, 32'd7,          32'hFFFF_FFFD, 5'd5,  32, 32'hFFFF_FFEB, 1'b0);
        run_op("mul_ovf",      1'b1, 32'h0001_0000,  32'h0001_0000, 5'd6,  32, 32'h0000_0000, 1'b1);
        run_op("mul_max",      1'b1, 32'h7FFF_FFFF,  32'd1,         5'd7,  32, 32'h7FFF_FFFF, 1'b0);
        run_op("mul_min_sq",   1'b1, 32'h8000_0000,  32'h8000_0000, 5'd8,  32, 32'h0000_0000, 1'b1);
        run_op("mul_neg_neg",  1'b1, 32'hFFFF_FFFB,  32'hFFFF_FFFA, 5'd9,  32, 32'h0000_001E, 1'b0);
        run_op("div_-7/2",     1'b0, 32'hFFFF_FFF9,  32'd2,         5'd10, 32, 32'hFFFF_FFFD, 1'b0);
        run_op("div_-100/-7",  1'b0, 32'hFFFF_FF9C,  32'hFFFF_FFF9, 5'd11, 32, 32'h0000_000E, 1'b0);
        run_op("div_by_zero",  1'b0, 32'd5,          32'd0,         5'd12, 1,  32'h0000_0000, 1'b1);
        run_op("div_min/-1",   1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 5'd13, 32, 32'h8000_0000, 1'b1);

        // Backpressure: result held for 10 cycles while a MULT pulse must be ignored.
        @(negedge clock);
        ctrl_DIV = 1'b1; data_operandA = 32'd100; data_operandB = 32'd7;
        ctrl_destReg = 5'd14; wb_ready = 1'b0;
        @(negedge clock);
        ctrl_DIV = 1'b0;
        repeat (32) @(negedge clock);
        check("bp_valid", 32'(wb_valid), 32'd1);
        saw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            ctrl_MULT = (i == 3);
            data_operandA = 32'd9; data_operandB = 32'd9; ctrl_destReg = 5'd2;
            @(negedge clock);
            saw |= (wb_valid !== 1'b1) || (wb_data !== 32'd14) ||
                   (wb_reg !== 5'd14) || (wb_exception !== 1'b0);
        end
        ctrl_MULT = 1'b0;
        check("bp_hold", 32'(saw), 32'd0);
        check("bp_data", wb_data, 32'd14);
        // Start pulse on the handshake edge is ignored.
        wb_ready = 1'b1; ctrl_MULT = 1'b1;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        check("bp_hs_valid", 32'(wb_valid), 32'd0);
        check("bp_hs_busy", 32'(busy), 32'd0);
        @(negedge clock);
        check("bp_idle_busy", 32'(busy), 32'd0);

        // Asynchronous abort in the middle of a multiply.
        ctrl_MULT = 1'b1; data_operandA = 32'd1234; data_operandB = 32'd5; ctrl_destReg = 5'd3;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        repeat (10) @(negedge clock);
        check("abort_busy_pre", 32'(busy), 32'd1);
        ctrl_reset = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(wb_valid), 32'd0);
        check("abort_data", wb_data, 32'd0);
        check("abort_reg", 32'(wb_reg), 32'd0);
        check("abort_exc", 32'(wb_exception), 32'd0);
        @(negedge clock);
        ctrl_reset = 1'b0;
        saw = 1'b0;
        repeat (40) begin
            @(negedge clock);
            saw |= wb_valid | busy;
        end
        check("abort_no_write", 32'(saw), 32'd0);
        run_op("mul_6x7", 1'b1, 32'd6, 32'd7, 5'd4, 32, 32'd42, 1'b0);

        // Both start pulses together are ignored.
        @(negedge clock);
        ctrl_MULT = 1'b1; ctrl_DIV = 1'b1; data_operandA = 32'd3; data_operandB = 32'd4;
        ctrl_destReg = 5'd1;
        @(negedge clock);
        ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
        saw = busy;
        repeat (3) begin
            @(negedge clock);
            saw |= busy;
        end
        check("both_ignored", 32'(saw), 32'd0);

        // Destination register 0 bypasses DONE.
        ctrl_MULT = 1'b1; data_operandA = 32'd3; data_operandB = 32'd4; ctrl_destReg = 5'd0;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        check("r0_busy_e0", 32'(busy), 32'd1);
        saw = wb_valid;
        repeat (31) begin
            @(negedge clock);
            saw |= wb_valid;
        end
        check("r0_busy_e31", 32'(busy), 32'd1);
        @(negedge clock);
        saw |= wb_valid;
        check("r0_busy_e32", 32'(busy), 32'd0);
        repeat (3) begin
            @(negedge clock);
            saw |= wb_valid;
        end
        check("r0_no_valid", 32'(saw), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
